// File: rtl/forward_ctrl.sv
// Pipeline forwarding and hazard controller: tracks destination tags from EXE back through the
// write-back stages, picks per-operand bypass sources and raises a stall for unresolvable hazards.
module forward_ctrl #(
   parameter int REG_W   = 4,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2,
   parameter int CNT_W   = 16,
   localparam int SEL_W  = $clog2(DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fu_en,
   input  logic                       freeze,
   input  logic                       flush,
   input  logic                       id_valid,
   input  logic [NUM_SRC*REG_W-1:0]   id_src,
   input  logic [NUM_SRC-1:0]         id_src_used,
   input  logic [REG_W-1:0]           id_dest,
   input  logic                       id_wb_en,
   input  logic                       id_mem_read,
   output logic                       hazard_stall,
   output logic [NUM_SRC*SEL_W-1:0]   sel_src,
   output logic [CNT_W-1:0]           stall_cnt
);

   logic                            e_valid;
   logic                            e_wb_en;
   logic                            e_mem_read;
   logic [REG_W-1:0]                e_dest;
   logic [NUM_SRC-1:0][REG_W-1:0]   e_src;
   logic [NUM_SRC-1:0]              e_src_used;

   logic [DEPTH:1]                  s_valid;
   logic [DEPTH:1]                  s_wb_en;
   logic [DEPTH:1]                  s_mem_read;
   logic [DEPTH:1][REG_W-1:0]       s_dest;

   logic                            load_use;
   logic                            raw_hit;

   // Hazard detection; the oldest stage is skipped because the register file writes before it reads.
   always_comb begin
      load_use = 1'b0;
      raw_hit  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_valid && id_src_used[i]) begin
            if (e_valid && e_wb_en && (id_src[i*REG_W +: REG_W] == e_dest)) begin
               raw_hit = 1'b1;
               if (e_mem_read) begin
                  load_use = 1'b1;
               end
            end
            for (int k = 1; k < DEPTH; k++) begin
               if (s_valid[k] && s_wb_en[k] && (id_src[i*REG_W +: REG_W] == s_dest[k])) begin
                  raw_hit = 1'b1;
               end
            end
         end
      end
      if (flush) begin
         hazard_stall = 1'b0;
      end else if (fu_en) begin
         hazard_stall = load_use;
      end else begin
         hazard_stall = raw_hit;
      end
   end

   // Scanning oldest-to-youngest lets the youngest matching producer overwrite the select last.
   always_comb begin
      sel_src = '0;
      if (fu_en && e_valid) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (e_src_used[i]) begin
               for (int k = DEPTH; k >= 1; k--) begin
                  if (s_valid[k] && s_wb_en[k] && (e_src[i] == s_dest[k])) begin
                     sel_src[i*SEL_W +: SEL_W] = SEL_W'(k);
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_valid    <= 1'b0;
         e_wb_en    <= 1'b0;
         e_mem_read <= 1'b0;
         e_dest     <= '0;
         e_src      <= '0;
         e_src_used <= '0;
         s_valid    <= '0;
         s_wb_en    <= '0;
         s_mem_read <= '0;
         s_dest     <= '0;
         stall_cnt  <= '0;
      end else if (!freeze) begin
         e_valid    <= id_valid && !flush && !hazard_stall;
         e_wb_en    <= id_wb_en;
         e_mem_read <= id_mem_read;
         e_dest     <= id_dest;
         e_src      <= id_src;
         e_src_used <= id_src_used;
         s_valid[1]    <= e_valid;
         s_wb_en[1]    <= e_wb_en;
         s_mem_read[1] <= e_mem_read;
         s_dest[1]     <= e_dest;
         for (int k = 2; k <= DEPTH; k++) begin
            s_valid[k]    <= s_valid[k-1];
            s_wb_en[k]    <= s_wb_en[k-1];
            s_mem_read[k] <= s_mem_read[k-1];
            s_dest[k]     <= s_dest[k-1];
         end
         if (hazard_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_forward_ctrl.sv
// Bench for forward_ctrl: directed hazard scenarios then random traffic, all compared against
// a queue-based tag model; a second instance with a 2-bit counter exercises saturation.
module tb_forward_ctrl;

   localparam int REG_W   = 4;
   localparam int NUM_SRC = 2;
   localparam int DEPTH   = 2;
   localparam int CNT_W   = 16;
   localparam int SEL_W   = $clog2(DEPTH + 1);

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      fu_en;
   logic                      freeze;
   logic                      flush;
   logic                      id_valid;
   logic [NUM_SRC*REG_W-1:0]  id_src;
   logic [NUM_SRC-1:0]        id_src_used;
   logic [REG_W-1:0]          id_dest;
   logic                      id_wb_en;
   logic                      id_mem_read;
   logic                      hazard_stall;
   logic [NUM_SRC*SEL_W-1:0]  sel_src;
   logic [CNT_W-1:0]          stall_cnt;
   logic                      hazard_stall_sat;
   logic [NUM_SRC*SEL_W-1:0]  sel_src_sat;
   logic [1:0]                stall_cnt_sat;

   always #5 clk = ~clk;

   forward_ctrl #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .fu_en(fu_en), .freeze(freeze), .flush(flush),
      .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used), .id_dest(id_dest),
      .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
      .hazard_stall(hazard_stall), .sel_src(sel_src), .stall_cnt(stall_cnt)
   );

   forward_ctrl #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .fu_en(fu_en), .freeze(freeze), .flush(flush),
      .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used), .id_dest(id_dest),
      .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
      .hazard_stall(hazard_stall_sat), .sel_src(sel_src_sat), .stall_cnt(stall_cnt_sat)
   );

   typedef struct {
      bit                            valid;
      bit                            wb_en;
      bit                            mem_read;
      bit [REG_W-1:0]                dest;
      bit [NUM_SRC-1:0][REG_W-1:0]   src;
      bit [NUM_SRC-1:0]              used;
   } tag_t;

   // Model: one EXE tag plus a queue of older tags, index 0 being the stage just behind EXE.
   tag_t        m_e;
   tag_t        m_s[$];
   int unsigned m_cnt;
   bit          m_last_stall;
   int          checks = 0;
   int          passed = 0;
   int          failed = 0;

   function automatic tag_t bubble();
      tag_t t;
      t.valid = 1'b0; t.wb_en = 1'b0; t.mem_read = 1'b0;
      t.dest = '0; t.src = '0; t.used = '0;
      return t;
   endfunction

   function automatic bit writes(tag_t t, bit [REG_W-1:0] r);
      return t.valid && t.wb_en && (t.dest == r);
   endfunction

   function automatic bit exp_stall();
      bit s = 1'b0;
      if (flush || rst) return 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_valid && id_src_used[i]) begin
            if (fu_en) begin
               s |= writes(m_e, id_src[i*REG_W +: REG_W]) && m_e.mem_read;
            end else begin
               s |= writes(m_e, id_src[i*REG_W +: REG_W]);
               for (int k = 0; k < DEPTH - 1; k++) s |= writes(m_s[k], id_src[i*REG_W +: REG_W]);
            end
         end
      end
      return s;
   endfunction

   function automatic logic [NUM_SRC*SEL_W-1:0] exp_sel();
      logic [NUM_SRC*SEL_W-1:0] v = '0;
      if (fu_en && m_e.valid) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (m_e.used[i]) begin
               for (int k = 0; k < DEPTH; k++) begin
                  if (writes(m_s[k], m_e.src[i])) begin
                     v[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                     break;
                  end
               end
            end
         end
      end
      return v;
   endfunction

   task automatic model_reset();
      m_e = bubble();
      m_s = {};
      for (int k = 0; k < DEPTH; k++) m_s.push_back(bubble());
      m_cnt = 0;
   endtask

   task automatic model_advance();
      bit   st;
      tag_t t;
      if (rst) begin
         model_reset();
         return;
      end
      if (freeze) return;
      st = exp_stall();
      m_cnt += st;
      m_s.push_front(m_e);
      void'(m_s.pop_back());
      t.valid = id_valid; t.wb_en = id_wb_en; t.mem_read = id_mem_read;
      t.dest = id_dest; t.src = id_src; t.used = id_src_used;
      m_e = (flush || st) ? bubble() : t;
   endtask

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic checkOutput(string tag);
      int unsigned sat_main;
      int unsigned sat_small;
      #1;
      sat_main  = (m_cnt > 65535) ? 65535 : m_cnt;
      sat_small = (m_cnt > 3) ? 3 : m_cnt;
      check({tag, " stall"},     32'(hazard_stall),     32'(exp_stall()));
      check({tag, " sel"},       32'(sel_src),          32'(exp_sel()));
      check({tag, " cnt"},       32'(stall_cnt),        sat_main);
      check({tag, " sat_stall"}, 32'(hazard_stall_sat), 32'(exp_stall()));
      check({tag, " sat_cnt"},   32'(stall_cnt_sat),    sat_small);
   endtask

   task automatic applyStimulus(bit v, bit [REG_W-1:0] dest, bit wb, bit mr,
                                bit [REG_W-1:0] s0, bit [REG_W-1:0] s1, bit [1:0] used);
      id_valid    = v;
      id_dest     = dest;
      id_wb_en    = wb;
      id_mem_read = mr;
      id_src      = {s1, s0};
      id_src_used = used;
   endtask

   task automatic tick(string tag);
      if (rst) model_reset();
      checkOutput(tag);
      m_last_stall = exp_stall();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   // Holds the current ID instruction until it is accepted, as the real front end would.
   task automatic issue(string tag);
      bit done = 1'b0;
      for (int n = 0; n < 8; n++) begin
         tick(tag);
         if (!m_last_stall) begin
            done = 1'b1;
            break;
         end
      end
      check({tag, " issue_timeout"}, 32'(done), 32'd1);
   endtask

   task automatic nop(string tag);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
      tick(tag);
   endtask

   task automatic doReset();
      rst = 1'b1;
      model_reset();
      tick("reset");
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; fu_en = 1'b1; freeze = 1'b0; flush = 1'b0;
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
      model_reset();
      @(posedge clk);
      #1;
      tick("reset_hold");
      rst = 1'b0;
      nop("after_reset");

      // ALU chain: forward from MEM, then from WB with an unrelated op in between.
      applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 4'd1, 4'd1, 2'b11);
      issue("alu_prod");
      applyStimulus(1'b1, 4'd8, 1'b1, 1'b0, 4'd3, 4'd9, 2'b01);
      issue("alu_cons");
      #1;
      check("alu_sel_mem", 32'(sel_src[0 +: SEL_W]), 32'd1);
      applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
      issue("alu_prod2");
      applyStimulus(1'b1, 4'd9, 1'b1, 1'b0, 4'd10, 4'd11, 2'b11);
      issue("alu_unrel");
      applyStimulus(1'b1, 4'd8, 1'b1, 1'b0, 4'd3, 4'd0, 2'b01);
      issue("alu_cons2");
      #1;
      check("alu_sel_wb", 32'(sel_src[0 +: SEL_W]), 32'd2);
      nop("alu_tail");

      // Load-use: one bubble, counter steps by one.
      applyStimulus(1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 4'd0, 2'b00);
      issue("ld_prod");
      applyStimulus(1'b1, 4'd6, 1'b1, 1'b0, 4'd0, 4'd5, 2'b10);
      #1;
      check("ld_stall", 32'(hazard_stall), 32'd1);
      issue("ld_cons");
      check("ld_cnt", 32'(stall_cnt), 32'd1);
      nop("ld_tail");

      // Priority: two producers of r7, then with the younger not writing back.
      applyStimulus(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
      issue("pri_old");
      applyStimulus(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
      issue("pri_young");
      applyStimulus(1'b1, 4'd1, 1'b1, 1'b0, 4'd7, 4'd7, 2'b11);
      issue("pri_cons");
      #1;
      check("pri_sel_both", 32'(sel_src), 32'(5));
      applyStimulus(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
      issue("pri_old2");
      applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00);
      issue("pri_nowb");
      applyStimulus(1'b1, 4'd1, 1'b1, 1'b0, 4'd7, 4'd0, 2'b01);
      issue("pri_cons2");
      #1;
      check("pri_sel_wb", 32'(sel_src[0 +: SEL_W]), 32'd2);
      nop("pri_tail");

      // Stall-only mode: two stall cycles per dependent pair; repeated to saturate the small counter.
      doReset();
      fu_en = 1'b0;
      for (int r = 0; r < 3; r++) begin
         applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
         issue("stl_prod");
         applyStimulus(1'b1, 4'd4, 1'b1, 1'b0, 4'd2, 4'd0, 2'b01);
         issue("stl_cons");
         if (r == 0) check("stl_cnt", 32'(stall_cnt), 32'd2);
         #1;
         check("stl_sel", 32'(sel_src), 32'd0);
      end
      check("stl_sat", 32'(stall_cnt_sat), 32'd3);
      fu_en = 1'b1;
      nop("stl_tail");

      // Flush beats load-use, then freeze holds everything.
      applyStimulus(1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 4'd0, 2'b00);
      issue("fl_prod");
      applyStimulus(1'b1, 4'd6, 1'b1, 1'b0, 4'd5, 4'd0, 2'b01);
      flush = 1'b1;
      #1;
      check("fl_stall", 32'(hazard_stall), 32'd0);
      tick("fl_cons");
      flush = 1'b0;
      freeze = 1'b1;
      applyStimulus(1'b1, 4'd9, 1'b1, 1'b0, 4'd5, 4'd5, 2'b11);
      for (int n = 0; n < 3; n++) tick("frz");
      freeze = 1'b0;
      nop("frz_tail");

      // Reset in the middle of a load-use stall.
      applyStimulus(1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 4'd0, 2'b00);
      issue("rs_prod");
      applyStimulus(1'b1, 4'd6, 1'b1, 1'b0, 4'd5, 4'd0, 2'b01);
      #1;
      check("rs_stall_before", 32'(hazard_stall), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("rs_stall_now", 32'(hazard_stall), 32'd0);
      check("rs_cnt_now", 32'(stall_cnt), 32'd0);
      model_reset();
      tick("rs_hold");
      rst = 1'b0;
      tick("rs_release");

      // Random traffic over a small register space to provoke frequent matches.
      for (int n = 0; n < 400; n++) begin
         rst    = ($urandom_range(0, 99) == 0);
         fu_en  = ($urandom_range(0, 9) != 0);
         freeze = ($urandom_range(0, 6) == 0);
         flush  = ($urandom_range(0, 9) == 0);
         applyStimulus(1'($urandom_range(0, 4) != 0), 4'($urandom_range(0, 3)),
                       1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 9) < 3),
                       4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)));
         tick("rand");
      end
      rst = 1'b0;
      freeze = 1'b0;
      flush = 1'b0;
      nop("final");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
